ifu_fetch_line_buffer: RTL and testbench



---
 rtl/ifu_pkg.sv | 25 ++
 rtl/ifu_line_fifo.sv | 59 +++++
 rtl/ifu_fetch_line_buffer.sv | 122 ++++++++++++
 tb/tb_ifu_fetch_line_buffer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths, fetch FSM states and line entry type
package ifu_pkg;

  localparam int ADDR_W     = 34;
  localparam int LINE_W     = 256;
  localparam int INST_W     = 32;
  localparam int SLOTS      = LINE_W / INST_W;
  localparam int SLOT_W     = $clog2(SLOTS);
  localparam int LINE_OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROPWAIT
  } fetch_state_e;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [ADDR_W-1:0] line_pc;
    logic [SLOT_W-1:0] start_slot;
  } line_entry_t;

endpackage

// File: rtl/ifu_line_fifo.sv
// rtl/ifu_line_fifo.sv - DEPTH-entry line FIFO with flush; exposes head and the
// start slot of the entry behind the head.
module ifu_line_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  line_entry_t              push_entry_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output line_entry_t              head_o,
  output logic [SLOT_W-1:0]        next_start_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  line_entry_t   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, nxt_ptr;
  logic [CW-1:0] count_q;
  logic          full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);
  assign nxt_ptr = rd_ptr_q + PW'(1);

  assign count_o      = count_q;
  assign head_o       = mem_q[rd_ptr_q];
  assign next_start_o = mem_q[nxt_ptr].start_slot;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= nxt_ptr;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/ifu_fetch_line_buffer.sv
// rtl/ifu_fetch_line_buffer.sv - sequential line fetch toward the Icache, line
// buffering and per-instruction hand-off to decode, with redirect flush.
module ifu_fetch_line_buffer
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_req_valid,
  output logic [ADDR_W-1:0] o_req_addr,
  input  logic              i_req_ready,
  input  logic              i_resp_valid,
  input  logic [LINE_W-1:0] i_resp_data,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, pend_addr_q;
  logic              first_q;
  logic [SLOT_W-1:0] first_slot_q, rd_slot_q, rd_slot_d;

  logic [CW-1:0]     count, cnt_after;
  logic              empty, push, pop, req_fire, inst_fire, credit_after, outstanding;
  line_entry_t       head, push_entry;
  logic [SLOT_W-1:0] next_start;
  logic              unused_ok;

  assign req_fire    = (state_q == REQ) && i_req_ready;
  assign outstanding = (state_q == WAIT) || (state_q == DROPWAIT);
  assign push        = (state_q == WAIT) && i_resp_valid && !i_redirect_valid;
  assign inst_fire   = !empty && i_inst_ready;
  assign pop         = inst_fire && (rd_slot_q == SLOT_W'(SLOTS - 1)) && !i_redirect_valid;

  assign push_entry.data       = i_resp_data;
  assign push_entry.line_pc    = pend_addr_q;
  assign push_entry.start_slot = first_q ? first_slot_q : '0;

  ifu_line_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (i_redirect_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (count),
    .empty_o      (empty),
    .head_o       (head),
    .next_start_o (next_start)
  );

  always_comb begin
    cnt_after = count;
    if (push && !pop)      cnt_after = count + CW'(1);
    else if (pop && !push) cnt_after = count - CW'(1);
    credit_after = (cnt_after < CW'(DEPTH));
  end

  // Whichever entry becomes head starts reading at its own start slot.
  always_comb begin
    rd_slot_d = rd_slot_q;
    if (pop) begin
      if (count == CW'(1)) rd_slot_d = push ? push_entry.start_slot : '0;
      else                 rd_slot_d = next_start;
    end else if (inst_fire) begin
      rd_slot_d = rd_slot_q + SLOT_W'(1);
    end else if (push && empty) begin
      rd_slot_d = push_entry.start_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= '0;
      pend_addr_q  <= '0;
      first_q      <= 1'b0;
      first_slot_q <= '0;
      rd_slot_q    <= '0;
    end else if (i_redirect_valid) begin
      fetch_pc_q   <= {i_redirect_pc[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
      first_q      <= 1'b1;
      first_slot_q <= i_redirect_pc[LINE_OFF_W-1:2];
      rd_slot_q    <= '0;
      // A request still in flight after this cycle must have its line dropped.
      if (req_fire || (outstanding && !i_resp_valid)) state_q <= DROPWAIT;
      else                                            state_q <= REQ;
    end else begin
      rd_slot_q <= rd_slot_d;
      case (state_q)
        REQ: if (i_req_ready) begin
          pend_addr_q <= fetch_pc_q;
          fetch_pc_q  <= fetch_pc_q + ADDR_W'(LINE_W / 8);
          state_q     <= WAIT;
        end
        WAIT: if (i_resp_valid) begin
          first_q <= 1'b0;
          state_q <= credit_after ? REQ : HOLD;
        end
        HOLD:     if (count < CW'(DEPTH)) state_q <= REQ;
        DROPWAIT: if (i_resp_valid)       state_q <= REQ;
        default:  state_q <= state_q;
      endcase
    end
  end

  assign o_req_valid  = (state_q == REQ);
  assign o_req_addr   = fetch_pc_q;
  assign o_inst_valid = !empty;
  assign o_inst       = empty ? '0 : head.data[rd_slot_q*INST_W +: INST_W];
  assign o_inst_pc    = empty ? '0 : {head.line_pc[ADDR_W-1:LINE_OFF_W], rd_slot_q, 2'b00};

  assign unused_ok = ^{i_redirect_pc[1:0], head.start_slot};

endmodule

// File: tb/tb_ifu_fetch_line_buffer.sv
// tb/tb_ifu_fetch_line_buffer.sv - table vectors plus directed multi-cycle
// sequences for ifu_fetch_line_buffer.
module tb_ifu_fetch_line_buffer;
  import ifu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_redirect_valid;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic              o_req_valid;
  logic [ADDR_W-1:0] o_req_addr;
  logic              i_req_ready;
  logic              i_resp_valid;
  logic [LINE_W-1:0] i_resp_data;
  logic              o_inst_valid;
  logic [INST_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_inst_pc;
  logic              i_inst_ready;

  ifu_fetch_line_buffer #(.DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_req_valid      (o_req_valid),
    .o_req_addr       (o_req_addr),
    .i_req_ready      (i_req_ready),
    .i_resp_valid     (i_resp_valid),
    .i_resp_data      (i_resp_data),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit                rv;
    logic [ADDR_W-1:0] rpc;
    bit                rq_rdy;
    bit                rs_v;
    logic [ADDR_W-1:0] rs_addr;
    bit                i_rdy;
    bit                e_rq_v;
    logic [ADDR_W-1:0] e_rq_addr;
    bit                e_iv;
    logic [ADDR_W-1:0] e_pc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int n_req = 0;
  int n_inst;
  logic [ADDR_W-1:0] req_log [16];
  bit                ic_pend = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0;
  localparam logic [LINE_W-1:0] STALE = {8{32'hDEAD_BEEF}};
  vec_t tbl [11];

  function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
    return pc[31:0] ^ 32'h5EED_0000;
  endfunction

  function automatic logic [LINE_W-1:0] make_line(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < SLOTS; k++) l[k*INST_W +: INST_W] = inst_of(a + ADDR_W'(4 * k));
    return l;
  endfunction

  function automatic vec_t mk(input bit rv, input logic [ADDR_W-1:0] rpc, input bit rq_rdy,
                              input bit rs_v, input logic [ADDR_W-1:0] rs_addr, input bit i_rdy,
                              input bit e_rq_v, input logic [ADDR_W-1:0] e_rq_addr,
                              input bit e_iv, input logic [ADDR_W-1:0] e_pc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rq_rdy = rq_rdy; v.rs_v = rs_v; v.rs_addr = rs_addr;
    v.i_rdy = i_rdy; v.e_rq_v = e_rq_v; v.e_rq_addr = e_rq_addr; v.e_iv = e_iv; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit erv, input logic [ADDR_W-1:0] ea,
                           input bit eiv, input logic [ADDR_W-1:0] epc);
    chk($sformatf("%s req_valid", tag), 64'(o_req_valid), 64'(erv));
    if (erv) chk($sformatf("%s req_addr", tag), 64'(o_req_addr), 64'(ea));
    chk($sformatf("%s inst_valid", tag), 64'(o_inst_valid), 64'(eiv));
    if (eiv) begin
      chk($sformatf("%s inst_pc", tag), 64'(o_inst_pc), 64'(epc));
      chk($sformatf("%s inst", tag), 64'(o_inst), 64'(inst_of(epc)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_req_ready      = 1'b0;
    i_resp_valid     = 1'b0;
    i_resp_data      = '0;
  endtask

  task automatic redirect(input logic [ADDR_W-1:0] pc);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = pc;
  endtask

  // Icache model: accepts a request, answers one cycle later (or, with
  // sync_last, only when the buffer is empty or the head is on its last slot).
  task automatic icache_cycle(input bit sync_last);
    clear_in();
    if (ic_pend && (!sync_last || !o_inst_valid || o_inst_pc[4:2] == 3'd7)) begin
      i_resp_valid = 1'b1;
      i_resp_data  = make_line(ic_addr);
      ic_pend      = 1'b0;
    end else if (!ic_pend && o_req_valid) begin
      i_req_ready = 1'b1;
      ic_pend     = 1'b1;
      ic_addr     = o_req_addr;
      if (n_req < 16) req_log[n_req] = o_req_addr;
      n_req++;
    end
    step();
  endtask

  initial begin
    int w;

    tbl[0]  = mk(1, 'h1008, 0, 0, 0,       0, 0, 0,       0, 0);
    tbl[1]  = mk(0, 0,      1, 0, 0,       0, 1, 'h1000, 0, 0);
    tbl[2]  = mk(0, 0,      0, 1, 'h1000, 0, 0, 0,       0, 0);
    tbl[3]  = mk(0, 0,      0, 0, 0,       0, 1, 'h1020, 1, 'h1008);
    tbl[4]  = mk(0, 0,      0, 0, 0,       1, 1, 'h1020, 1, 'h1008);
    tbl[5]  = mk(0, 0,      0, 0, 0,       1, 1, 'h1020, 1, 'h100C);
    tbl[6]  = mk(0, 0,      0, 0, 0,       1, 1, 'h1020, 1, 'h1010);
    tbl[7]  = mk(0, 0,      0, 0, 0,       1, 1, 'h1020, 1, 'h1014);
    tbl[8]  = mk(0, 0,      0, 0, 0,       1, 1, 'h1020, 1, 'h1018);
    tbl[9]  = mk(0, 0,      0, 0, 0,       1, 1, 'h1020, 1, 'h101C);
    tbl[10] = mk(0, 0,      0, 0, 0,       0, 1, 'h1020, 0, 0);

    clear_in();
    i_inst_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    step();
    chk("reset req_valid", 64'(o_req_valid), 64'd0);
    chk("reset inst_valid", 64'(o_inst_valid), 64'd0);
    chk("reset req_addr", 64'(o_req_addr), 64'd0);
    chk("reset inst", 64'(o_inst), 64'd0);
    chk("reset inst_pc", 64'(o_inst_pc), 64'd0);
    rst = 1'b0;
    step();
    step();
    chk("idle no fetch", 64'(o_req_valid), 64'd0);

    // Redirect to 0x1008: one line, six instructions, next request 0x1020.
    for (int i = 0; i < 11; i++) begin
      check_out($sformatf("vec%0d", i), tbl[i].e_rq_v, tbl[i].e_rq_addr, tbl[i].e_iv, tbl[i].e_pc);
      i_redirect_valid = tbl[i].rv;
      i_redirect_pc    = tbl[i].rpc;
      i_req_ready      = tbl[i].rq_rdy;
      i_resp_valid     = tbl[i].rs_v;
      i_resp_data      = tbl[i].rs_v ? make_line(tbl[i].rs_addr) : '0;
      i_inst_ready     = tbl[i].i_rdy;
      step();
    end

    // Decoder stalled: credit limits fetch to two lines, then HOLD.
    clear_in();
    i_inst_ready = 1'b0;
    redirect('h5000);
    step();
    n_req = 0;
    for (int c = 0; c < 8; c++) icache_cycle(1'b0);
    chk("hold req count", 64'(n_req), 64'd2);
    chk("hold req0 addr", 64'(req_log[0]), 64'h5000);
    chk("hold req1 addr", 64'(req_log[1]), 64'h5020);
    chk("hold req_valid", 64'(o_req_valid), 64'd0);
    i_inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain pc%0d", k), 64'(o_inst_pc), 64'h5000 + 64'(4 * k));
      chk($sformatf("drain inst%0d", k), 64'(o_inst), 64'(inst_of(ADDR_W'('h5000 + 4 * k))));
      step();
    end
    i_inst_ready = 1'b0;
    check_out("after drain", 1'b0, '0, 1'b1, 'h5020);
    w = 0;
    while (!o_req_valid && w < 4) begin
      step();
      w++;
    end
    chk("third req issued", 64'(o_req_valid), 64'd1);
    chk("third req addr", 64'(o_req_addr), 64'h5040);

    // Redirect while WAIT: stale line must never surface.
    i_req_ready = 1'b1;
    step();
    clear_in();
    redirect('h2000);
    step();
    check_out("dropwait", 1'b0, '0, 1'b0, '0);
    clear_in();
    i_resp_valid = 1'b1;
    i_resp_data  = STALE;
    step();
    clear_in();
    check_out("after stale", 1'b1, 'h2000, 1'b0, '0);
    i_req_ready = 1'b1;
    step();
    clear_in();
    i_resp_valid = 1'b1;
    i_resp_data  = make_line('h2000);
    step();
    clear_in();
    check_out("post-drop line", 1'b1, 'h2020, 1'b1, 'h2000);

    // Redirect coinciding with a response, then with a request accept.
    i_req_ready = 1'b1;
    step();
    clear_in();
    redirect('h6004);
    i_resp_valid = 1'b1;
    i_resp_data  = make_line('h2020);
    step();
    clear_in();
    check_out("redir+resp", 1'b1, 'h6000, 1'b0, '0);
    redirect('h7010);
    i_req_ready = 1'b1;
    step();
    clear_in();
    check_out("redir+accept", 1'b0, '0, 1'b0, '0);
    i_resp_valid = 1'b1;
    i_resp_data  = STALE;
    step();
    clear_in();
    check_out("redir+accept drop", 1'b1, 'h7000, 1'b0, '0);
    i_req_ready = 1'b1;
    step();
    clear_in();
    i_resp_valid = 1'b1;
    i_resp_data  = make_line('h7000);
    step();
    clear_in();
    check_out("redir+accept line", 1'b1, 'h7020, 1'b1, 'h7010);

    // Fetch address wrap at the top of the physical space.
    redirect(34'h3_FFFF_FFE0);
    step();
    clear_in();
    check_out("wrap req", 1'b1, 34'h3_FFFF_FFE0, 1'b0, '0);
    i_req_ready = 1'b1;
    step();
    clear_in();
    chk("wrap wait req_valid", 64'(o_req_valid), 64'd0);
    i_resp_valid = 1'b1;
    i_resp_data  = make_line(34'h3_FFFF_FFE0);
    step();
    clear_in();
    check_out("wrap next", 1'b1, '0, 1'b1, 34'h3_FFFF_FFE0);

    // Responses timed to land with the last-slot pop: PCs stay contiguous.
    i_inst_ready = 1'b1;
    redirect('h4000);
    step();
    clear_in();
    ic_pend = 1'b0;
    n_inst  = 0;
    for (int c = 0; c < 200 && n_inst < 24; c++) begin
      if (o_inst_valid) begin
        chk($sformatf("stream pc%0d", n_inst), 64'(o_inst_pc), 64'h4000 + 64'(4 * n_inst));
        chk($sformatf("stream inst%0d", n_inst), 64'(o_inst), 64'(inst_of(ADDR_W'('h4000 + 4 * n_inst))));
        n_inst++;
      end
      icache_cycle(1'b1);
    end
    chk("stream count", 64'(n_inst), 64'd24);

    // Reset mid-operation: a late response is ignored.
    clear_in();
    i_inst_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_resp_valid = 1'b1;
    i_resp_data  = make_line('h9000);
    step();
    clear_in();
    chk("mid-reset req_valid", 64'(o_req_valid), 64'd0);
    chk("mid-reset inst_valid", 64'(o_inst_valid), 64'd0);
    chk("mid-reset req_addr", 64'(o_req_addr), 64'd0);
    chk("mid-reset inst", 64'(o_inst), 64'd0);
    chk("mid-reset inst_pc", 64'(o_inst_pc), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
